// File: rtl/fetch_pc_pkg.sv
// Shared constants, FSM states and redirect kinds for the instruction-fetch PC generator.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    RESET,
    RUN,
    PEND,
    ADEL
  } fetch_state_e;

  typedef enum logic [2:0] {
    RK_NONE,
    RK_BR,
    RK_J,
    RK_JR,
    RK_EXC,
    RK_ERET
  } redir_kind_e;

  // Exception-class redirects have no delay slot.
  function automatic logic kind_nods(input redir_kind_e kind);
    return (kind == RK_EXC) || (kind == RK_ERET);
  endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory request handshake between the fetch PC generator and instruction memory.
interface fetch_pc_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              inst_req_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              kill_o;
  logic              inst_ready_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    output kill_o,
    input  inst_ready_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    input  kill_o,
    output inst_ready_i
  );

endinterface

// File: rtl/fetch_pc_target_calc.sv
// Combinational redirect priority mux: picks the winning redirect, its target and its delay-slot PC.
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              br_taken,
  input  logic [15:0]       br_off,
  input  logic              j,
  input  logic [25:0]       j_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              exc,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output redir_kind_e       kind,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] ds
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;

  assign pc4    = id_pc + ADDR_W'(4);
  assign br_tgt = pc4 + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};
  // Masked merge keeps the region bits without slicing above bit 27, so ADDR_W == 28 is legal.
  assign j_tgt  = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({j_index, 2'b00});
  assign ds     = pc4;

  always_comb begin
    kind   = RK_NONE;
    target = '0;
    if (exc) begin
      kind   = RK_EXC;
      target = EXC_VECTOR;
    end else if (eret) begin
      kind   = RK_ERET;
      target = epc;
    end else if (jr) begin
      kind   = RK_JR;
      target = jr_target;
    end else if (j) begin
      kind   = RK_J;
      target = j_tgt;
    end else if (br_taken) begin
      kind   = RK_BR;
      target = br_tgt;
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// Instruction-fetch PC sequencer: request handshake, stall, delay-slot redirects and exception vectoring.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic              br_taken_i,
  input  logic [15:0]       br_off_i,
  input  logic              j_i,
  input  logic [25:0]       j_index_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  fetch_pc_if.master        imem,
  output logic              adel_o,
  output logic              ce_o
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_ds;
  logic              pend_nods;

  redir_kind_e       rd_kind;
  logic [ADDR_W-1:0] rd_target;
  logic [ADDR_W-1:0] rd_ds;
  logic              rd_nods;

  logic              req;
  logic              acc;
  logic              take_new;
  logic              eff_valid;
  logic [ADDR_W-1:0] eff_target;
  logic [ADDR_W-1:0] eff_ds;
  logic              eff_nods;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;

  pc_target_calc #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_calc (
    .id_pc     (id_pc_i),
    .br_taken  (br_taken_i),
    .br_off    (br_off_i),
    .j         (j_i),
    .j_index   (j_index_i),
    .jr        (jr_i),
    .jr_target (jr_target_i),
    .exc       (exc_i),
    .eret      (eret_i),
    .epc       (epc_i),
    .kind      (rd_kind),
    .target    (rd_target),
    .ds        (rd_ds)
  );

  assign rd_nods = kind_nods(rd_kind);
  assign req     = ce_o & ~stall_i & ~adel_o;
  assign acc     = req & imem.inst_ready_i;

  // A second delay-slot redirect while one is pending is ignored; exception-class ones always win.
  always_comb begin
    take_new = 1'b0;
    unique case (state)
      RESET:   take_new = 1'b0;
      RUN:     take_new = (rd_kind != RK_NONE);
      PEND:    take_new = rd_nods;
      ADEL:    take_new = (rd_kind == RK_EXC);
      default: take_new = 1'b0;
    endcase
  end

  // A redirect arriving with an accept is treated as if it were already pending.
  always_comb begin
    eff_valid  = take_new | (state == PEND);
    eff_target = take_new ? rd_target : pend_target;
    eff_ds     = take_new ? rd_ds     : pend_ds;
    eff_nods   = take_new ? rd_nods   : pend_nods;
  end

  always_comb begin
    pc_load = 1'b0;
    pc_next = pc;
    if (acc) begin
      pc_load = 1'b1;
      pc_next = eff_valid ? eff_target : pc + ADDR_W'(4);
    end else if (take_new && rd_nods && !req) begin
      pc_load = 1'b1;
      pc_next = rd_target;
    end
  end

  assign imem.inst_req_o  = req;
  assign imem.inst_addr_o = pc;
  assign imem.kill_o      = acc & eff_valid & (eff_nods | (pc != eff_ds));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RESET;
      pc          <= RESET_VECTOR;
      pend_target <= '0;
      pend_ds     <= '0;
      pend_nods   <= 1'b0;
      ce_o        <= 1'b0;
      adel_o      <= 1'b0;
    end else if (state == RESET) begin
      state <= RUN;
      ce_o  <= 1'b1;
    end else if (pc_load) begin
      pc        <= pc_next;
      pend_nods <= 1'b0;
      if (pc_next[1:0] != 2'b00) begin
        state  <= ADEL;
        adel_o <= 1'b1;
      end else begin
        state  <= RUN;
        adel_o <= 1'b0;
      end
    end else if (take_new) begin
      pend_target <= rd_target;
      pend_ds     <= rd_ds;
      pend_nods   <= rd_nods;
      state       <= PEND;
    end
  end

endmodule
